// File: rtl/dut_irq_arbiter.sv
// Interrupt arbiter for the timer: latches counter events into RIS, masks with IM,
// and locks the highest-priority pending source (round-robin on ties) into IIR/irq.
module dut_irq_arbiter #(
    parameter int NUM_SRC    = 3,
    parameter int PRIO_W     = 2,
    parameter int ID_W       = 2,
    parameter int GAP_CYCLES = 1
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,
    input  logic [NUM_SRC-1:0]        evt_i,
    input  logic [NUM_SRC-1:0]        im_i,
    input  logic [NUM_SRC*PRIO_W-1:0] prio_i,
    input  logic [NUM_SRC-1:0]        ris_clr_i,
    input  logic                      iir_ack_i,
    output logic [NUM_SRC-1:0]        ris_o,
    output logic [NUM_SRC-1:0]        mis_o,
    output logic [ID_W-1:0]           iir_id_o,
    output logic                      irq_o
);

    localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [SRC_W:0]   NUM_SRC_X = (SRC_W+1)'(NUM_SRC);
    localparam logic [SRC_W-1:0] LAST_SRC  = SRC_W'(NUM_SRC - 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOCKED = 2'd1,
        ST_GAP    = 2'd2
    } state_t;

    state_t             state_q,    state_d;
    logic [NUM_SRC-1:0] ris_q,      ris_d;
    logic [ID_W-1:0]    iir_id_q,   iir_id_d;
    logic               irq_q,      irq_d;
    logic [SRC_W-1:0]   rr_ptr_q,   rr_ptr_d;
    logic [SRC_W-1:0]   lock_src_q, lock_src_d;
    logic [GAP_W-1:0]   gap_cnt_q,  gap_cnt_d;

    logic [PRIO_W-1:0]  prio_arr [NUM_SRC];
    logic [NUM_SRC-1:0] ack_clr;
    logic [NUM_SRC-1:0] mis;
    logic               ack_hit;
    logic               win_found;
    logic [SRC_W-1:0]   win_src;
    logic [PRIO_W-1:0]  win_prio;

    assign mis     = ris_q & im_i;
    assign ack_hit = (state_q == ST_LOCKED) && iir_ack_i;

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        assign prio_arr[gi] = prio_i[gi*PRIO_W +: PRIO_W];
        assign ack_clr[gi]  = ack_hit && (lock_src_q == SRC_W'(gi));
    end

    // Scan from rr_ptr upward; strict '>' keeps the first-seen source on a tie.
    always_comb begin
        logic [SRC_W:0]   sum;
        logic [SRC_W-1:0] idx;
        win_found = 1'b0;
        win_src   = '0;
        win_prio  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            sum = {1'b0, rr_ptr_q} + (SRC_W+1)'(i);
            if (sum >= NUM_SRC_X) begin
                sum = sum - NUM_SRC_X;
            end
            idx = sum[SRC_W-1:0];
            if (mis[idx] && (!win_found || (prio_arr[idx] > win_prio))) begin
                win_found = 1'b1;
                win_src   = idx;
                win_prio  = prio_arr[idx];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        iir_id_d   = iir_id_q;
        irq_d      = irq_q;
        rr_ptr_d   = rr_ptr_q;
        lock_src_d = lock_src_q;
        gap_cnt_d  = gap_cnt_q;
        // An event in the same cycle as a clear or an ack always wins.
        ris_d      = (ris_q & ~(ris_clr_i | ack_clr)) | evt_i;

        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d    = ST_LOCKED;
                    lock_src_d = win_src;
                    iir_id_d   = ID_W'(win_src) + ID_W'(1);
                    irq_d      = 1'b1;
                end
            end
            ST_LOCKED: begin
                if (iir_ack_i) begin
                    state_d   = ST_GAP;
                    rr_ptr_d  = (lock_src_q == LAST_SRC) ? '0 : lock_src_q + SRC_W'(1);
                    iir_id_d  = '0;
                    irq_d     = 1'b0;
                    gap_cnt_d = '0;
                end else if (!mis[lock_src_q]) begin
                    state_d   = ST_GAP;
                    iir_id_d  = '0;
                    irq_d     = 1'b0;
                    gap_cnt_d = '0;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d   = ST_IDLE;
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: begin
                state_d  = ST_IDLE;
                iir_id_d = '0;
                irq_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q    <= ST_IDLE;
            ris_q      <= '0;
            iir_id_q   <= '0;
            irq_q      <= 1'b0;
            rr_ptr_q   <= '0;
            lock_src_q <= '0;
            gap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            ris_q      <= ris_d;
            iir_id_q   <= iir_id_d;
            irq_q      <= irq_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_src_q <= lock_src_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    assign ris_o    = ris_q;
    assign mis_o    = mis;
    assign iir_id_o = iir_id_q;
    assign irq_o    = irq_q;

endmodule
